// File: rtl/multicycle_ctrl.sv
// -----------------------------------------------------------------------------
// multicycle_ctrl
//   Control FSM for a multicycle processor. It sequences each instruction
//   through Fetch, Decode, Execute, Memory and Writeback, handshakes with the
//   instruction and data memories, honours datapath stalls, and aborts memory
//   handshakes that wait too long.
//
// Parameters
//   OP_W     opcode width
//   FUNC_W   R-type function-field width
//   TIMEOUT  maximum wait cycles in F or M before abort (0 disables)
//
// Ports
//   clk          sole clock, rising edge
//   reset        synchronous, active-high reset
//   op, func     instruction fields from instruction memory (latched in F)
//   iready       instruction memory has returned data
//   dready       data memory access is complete
//   stall        hold request from the datapath (honoured in D, E, W)
//   state        current state: F=001 D=010 E=011 M=100 W=101
//   ireq         instruction fetch request (F)
//   dreq         data memory request (M)
//   dwe          data memory write enable (M, SW only)
//   ir_we        instruction register write enable (F with iready)
//   rf_we        register file write enable (W, unstalled)
//   instr_done   one-cycle pulse in the last cycle of an instruction
//   err_illegal  one-cycle pulse on an undecodable opcode
//   err_timeout  one-cycle pulse on a handshake timeout
// -----------------------------------------------------------------------------
module multicycle_ctrl #(
  parameter int OP_W    = 6,
  parameter int FUNC_W  = 6,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [OP_W-1:0]   op,
  input  logic [FUNC_W-1:0] func,
  input  logic              iready,
  input  logic              dready,
  input  logic              stall,
  output logic [2:0]        state,
  output logic              ireq,
  output logic              dreq,
  output logic              dwe,
  output logic              ir_we,
  output logic              rf_we,
  output logic              instr_done,
  output logic              err_illegal,
  output logic              err_timeout
);

  // A zero TIMEOUT would give a zero-width counter; keep one bit in that case.
  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  localparam logic [OP_W-1:0] OP_R    = OP_W'(6'b000000);
  localparam logic [OP_W-1:0] OP_ADDI = OP_W'(6'b001000);
  localparam logic [OP_W-1:0] OP_J    = OP_W'(6'b000010);
  localparam logic [OP_W-1:0] OP_BEQ  = OP_W'(6'b000100);
  localparam logic [OP_W-1:0] OP_LW   = OP_W'(6'b100011);
  localparam logic [OP_W-1:0] OP_SW   = OP_W'(6'b101011);

  typedef enum logic [2:0] {
    S_F = 3'b001,
    S_D = 3'b010,
    S_E = 3'b011,
    S_M = 3'b100,
    S_W = 3'b101
  } state_t;

  typedef enum logic [2:0] {
    C_NOP  = 3'd0,
    C_R    = 3'd1,
    C_ADDI = 3'd2,
    C_J    = 3'd3,
    C_BEQ  = 3'd4,
    C_LW   = 3'd5,
    C_SW   = 3'd6,
    C_ILL  = 3'd7
  } cls_t;

  state_t            r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic [OP_W-1:0]   r_op;
  logic [FUNC_W-1:0] r_func;

  cls_t              w_cls;
  state_t            w_next;
  logic [CNT_W-1:0]  w_cnt_next;
  logic              w_hit;

  assign state = r_state;

  // The wait counter has reached the abort threshold (never when disabled).
  assign w_hit = (TIMEOUT > 0) && (r_cnt == CNT_W'(TIMEOUT));

  // Classify the latched instruction; only the latched fields are decoded.
  always_comb begin
    w_cls = C_ILL;
    case (r_op)
      OP_R: begin
        if (r_func == FUNC_W'(0)) begin
          w_cls = C_NOP;
        end else begin
          w_cls = C_R;
        end
      end
      OP_ADDI: w_cls = C_ADDI;
      OP_J:    w_cls = C_J;
      OP_BEQ:  w_cls = C_BEQ;
      OP_LW:   w_cls = C_LW;
      OP_SW:   w_cls = C_SW;
      default: w_cls = C_ILL;
    endcase
  end

  // Next state, wait counter and control outputs. Outputs depend on the
  // current inputs because ir_we and instr_done must fire in the same cycle
  // as the handshake or stall release that causes the transition.
  always_comb begin
    w_next      = r_state;
    w_cnt_next  = {CNT_W{1'b0}};
    ireq        = 1'b0;
    dreq        = 1'b0;
    dwe         = 1'b0;
    ir_we       = 1'b0;
    rf_we       = 1'b0;
    instr_done  = 1'b0;
    err_illegal = 1'b0;
    err_timeout = 1'b0;
    case (r_state)
      S_F: begin
        ireq = 1'b1;
        if (iready) begin
          ir_we  = 1'b1;
          w_next = S_D;
        end else if (w_hit) begin
          // Stay in F and re-request with a fresh count.
          err_timeout = 1'b1;
        end else begin
          w_cnt_next = r_cnt + CNT_W'(1);
        end
      end
      S_D: begin
        if (stall) begin
          w_next = S_D;
        end else begin
          case (w_cls)
            C_NOP, C_J: begin
              instr_done = 1'b1;
              w_next     = S_F;
            end
            C_ILL: begin
              err_illegal = 1'b1;
              w_next      = S_F;
            end
            default: w_next = S_E;
          endcase
        end
      end
      S_E: begin
        if (stall) begin
          w_next = S_E;
        end else begin
          case (w_cls)
            C_BEQ: begin
              instr_done = 1'b1;
              w_next     = S_F;
            end
            C_LW, C_SW: w_next = S_M;
            default:    w_next = S_W;
          endcase
        end
      end
      S_M: begin
        dreq = 1'b1;
        dwe  = (w_cls == C_SW);
        if (dready) begin
          if (w_cls == C_SW) begin
            instr_done = 1'b1;
            w_next     = S_F;
          end else begin
            w_next = S_W;
          end
        end else if (w_hit) begin
          // Abandon the instruction; no retire pulse.
          err_timeout = 1'b1;
          w_next      = S_F;
        end else begin
          w_cnt_next = r_cnt + CNT_W'(1);
        end
      end
      S_W: begin
        if (stall) begin
          w_next = S_W;
        end else begin
          rf_we      = 1'b1;
          instr_done = 1'b1;
          w_next     = S_F;
        end
      end
      default: w_next = S_F;
    endcase
  end

  // State, wait counter and instruction-field latches.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_F;
      r_cnt   <= {CNT_W{1'b0}};
      r_op    <= {OP_W{1'b0}};
      r_func  <= {FUNC_W{1'b0}};
    end else begin
      r_state <= w_next;
      r_cnt   <= w_cnt_next;
      if ((r_state == S_F) && iready) begin
        r_op   <= op;
        r_func <= func;
      end else begin
        r_op   <= r_op;
        r_func <= r_func;
      end
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// -----------------------------------------------------------------------------
// tb_multicycle_ctrl
//   Self-checking bench for multicycle_ctrl (TIMEOUT=3). Each scenario task
//   builds a table of per-cycle stimulus with the expected outputs for that
//   cycle; the expectation is queued when the stimulus is driven and popped
//   for comparison once the DUT outputs have settled.
//   Observation vector: {state[2:0], ireq, dreq, dwe, ir_we, rf_we,
//                        instr_done, err_illegal, err_timeout}
// -----------------------------------------------------------------------------
module tb_multicycle_ctrl;

  logic       clk;
  logic       reset;
  logic [5:0] op;
  logic [5:0] func;
  logic       iready;
  logic       dready;
  logic       stall;
  logic [2:0] state;
  logic       ireq, dreq, dwe, ir_we, rf_we, instr_done, err_illegal, err_timeout;
  logic [10:0] obs;

  int errors = 0;
  int checks = 0;
  logic [10:0] exp_q[$];

  typedef struct {
    logic       rst;
    logic       ir;
    logic       dr;
    logic       st;
    logic [5:0] op;
    logic [5:0] fn;
    logic       chk;
    logic [10:0] exp;
  } row_t;

  // Expected observation vectors, derived from the state encoding and the
  // output rules of the block.
  localparam logic [10:0] X_F   = {3'b001, 8'b1000_0000}; // F waiting
  localparam logic [10:0] X_FI  = {3'b001, 8'b1001_0000}; // F, iready: ir_we
  localparam logic [10:0] X_FT  = {3'b001, 8'b1000_0001}; // F timeout
  localparam logic [10:0] X_D   = {3'b010, 8'b0000_0000};
  localparam logic [10:0] X_DD  = {3'b010, 8'b0000_0100}; // D retire (NOP/J)
  localparam logic [10:0] X_DI  = {3'b010, 8'b0000_0010}; // D illegal
  localparam logic [10:0] X_E   = {3'b011, 8'b0000_0000};
  localparam logic [10:0] X_ED  = {3'b011, 8'b0000_0100}; // E retire (BEQ)
  localparam logic [10:0] X_M   = {3'b100, 8'b0100_0000}; // M load waiting
  localparam logic [10:0] X_MT  = {3'b100, 8'b0100_0001}; // M timeout
  localparam logic [10:0] X_MSD = {3'b100, 8'b0110_0100}; // M store done
  localparam logic [10:0] X_W   = {3'b101, 8'b0000_1100}; // W rf_we + retire
  localparam logic [10:0] X_WS  = {3'b101, 8'b0000_0000}; // W stalled

  localparam logic [5:0] OPC_R    = 6'b000000;
  localparam logic [5:0] OPC_ADDI = 6'b001000;
  localparam logic [5:0] OPC_J    = 6'b000010;
  localparam logic [5:0] OPC_BEQ  = 6'b000100;
  localparam logic [5:0] OPC_LW   = 6'b100011;
  localparam logic [5:0] OPC_SW   = 6'b101011;
  localparam logic [5:0] OPC_BAD  = 6'b111111;

  multicycle_ctrl #(.OP_W(6), .FUNC_W(6), .TIMEOUT(3)) dut (
    .clk         (clk),
    .reset       (reset),
    .op          (op),
    .func        (func),
    .iready      (iready),
    .dready      (dready),
    .stall       (stall),
    .state       (state),
    .ireq        (ireq),
    .dreq        (dreq),
    .dwe         (dwe),
    .ir_we       (ir_we),
    .rf_we       (rf_we),
    .instr_done  (instr_done),
    .err_illegal (err_illegal),
    .err_timeout (err_timeout)
  );

  assign obs = {state, ireq, dreq, dwe, ir_we, rf_we, instr_done, err_illegal, err_timeout};

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic row_t r(input logic rst, input logic ir, input logic dr,
                             input logic st, input logic [5:0] o,
                             input logic [5:0] f, input logic chk,
                             input logic [10:0] e);
    row_t x;
    x.rst = rst; x.ir = ir; x.dr = dr; x.st = st;
    x.op = o; x.fn = f; x.chk = chk; x.exp = e;
    return x;
  endfunction

  // Unchecked reset cycle used to start each scenario from a clean state.
  function automatic row_t rr();
    return r(1'b1, 1'b0, 1'b0, 1'b0, 6'd0, 6'd0, 1'b0, X_F);
  endfunction

  // Drive one table row at the falling edge and queue its expectation.
  task automatic drive_row(input row_t x);
    @(negedge clk);
    reset  = x.rst;
    iready = x.ir;
    dready = x.dr;
    stall  = x.st;
    op     = x.op;
    func   = x.fn;
    if (x.chk) exp_q.push_back(x.exp);
    #1;
  endtask

  task automatic test_reset();
    row_t rows[$];
    logic [10:0] e;
    rows.push_back(rr());
    rows.push_back(rr());
    rows.push_back(r(1'b0, 1'b0, 1'b0, 1'b0, OPC_LW, 6'd0, 1'b1, X_F));
    rows.push_back(r(1'b0, 1'b0, 1'b0, 1'b0, OPC_LW, 6'd0, 1'b1, X_F));
    for (int i = 0; i < rows.size(); i++) begin
      drive_row(rows[i]);
      if (rows[i].chk) begin
        e = exp_q.pop_front();
        checks++;
        if (obs !== e) begin
          errors++;
          $display("FAIL reset cyc%0d: got %b expected %b", i, obs, e);
        end
      end
    end
  endtask

  task automatic test_lw();
    row_t rows[$];
    logic [10:0] e;
    rows.push_back(rr());
    rows.push_back(r(1'b0, 1'b1, 1'b0, 1'b0, OPC_LW, 6'd0, 1'b1, X_FI));
    rows.push_back(r(1'b0, 1'b0, 1'b0, 1'b0, OPC_LW, 6'd0, 1'b1, X_D));
    rows.push_back(r(1'b0, 1'b0, 1'b0, 1'b0, OPC_LW, 6'd0, 1'b1, X_E));
    rows.push_back(r(1'b0, 1'b0, 1'b0, 1'b0, OPC_LW, 6'd0, 1'b1, X_M));
    rows.push_back(r(1'b0, 1'b0, 1'b0, 1'b0, OPC_LW, 6'd0, 1'b1, X_M));
    rows.push_back(r(1'b0, 1'b0, 1'b1, 1'b0, OPC_LW, 6'd0, 1'b1, X_M));
    rows.push_back(r(1'b0, 1'b0, 1'b0, 1'b0, OPC_LW, 6'd0, 1'b1, X_W));
    rows.push_back(r(1'b0, 1'b0, 1'b0, 1'b0, OPC_LW, 6'd0, 1'b1, X_F));
    for (int i = 0; i < rows.size(); i++) begin
      drive_row(rows[i]);
      if (rows[i].chk) begin
        e = exp_q.pop_front();
        checks++;
        if (obs !== e) begin
          errors++;
          $display("FAIL lw cyc%0d: got %b expected %b", i, obs, e);
        end
      end
    end
  endtask

  task automatic test_sw();
    row_t rows[$];
    logic [10:0] e;
    rows.push_back(rr());
    rows.push_back(r(1'b0, 1'b1, 1'b0, 1'b0, OPC_SW, 6'd0, 1'b1, X_FI));
    rows.push_back(r(1'b0, 1'b0, 1'b0, 1'b0, OPC_SW, 6'd0, 1'b1, X_D));
    rows.push_back(r(1'b0, 1'b0, 1'b0, 1'b0, OPC_SW, 6'd0, 1'b1, X_E));
    rows.push_back(r(1'b0, 1'b0, 1'b1, 1'b0, OPC_SW, 6'd0, 1'b1, X_MSD));
    rows.push_back(r(1'b0, 1'b0, 1'b0, 1'b0, OPC_SW, 6'd0, 1'b1, X_F));
    for (int i = 0; i < rows.size(); i++) begin
      drive_row(rows[i]);
      if (rows[i].chk) begin
        e = exp_q.pop_front();
        checks++;
        if (obs !== e) begin
          errors++;
          $display("FAIL sw cyc%0d: got %b expected %b", i, obs, e);
        end
      end
    end
  endtask

  task automatic test_illegal();
    row_t rows[$];
    logic [10:0] e;
    rows.push_back(rr());
    rows.push_back(r(1'b0, 1'b1, 1'b0, 1'b0, OPC_BAD, 6'd0, 1'b1, X_FI));
    rows.push_back(r(1'b0, 1'b0, 1'b0, 1'b0, OPC_BAD, 6'd0, 1'b1, X_DI));
    rows.push_back(r(1'b0, 1'b0, 1'b0, 1'b0, OPC_BAD, 6'd0, 1'b1, X_F));
    for (int i = 0; i < rows.size(); i++) begin
      drive_row(rows[i]);
      if (rows[i].chk) begin
        e = exp_q.pop_front();
        checks++;
        if (obs !== e) begin
          errors++;
          $display("FAIL illegal cyc%0d: got %b expected %b", i, obs, e);
        end
      end
    end
  endtask

  // F timeout with TIMEOUT=3: pulse on every 4th waiting F cycle; iready in
  // the same cycle the count reaches the threshold completes normally.
  task automatic test_timeout_f();
    row_t rows[$];
    logic [10:0] e;
    rows.push_back(rr());
    for (int k = 0; k < 2; k++) begin
      rows.push_back(r(1'b0, 1'b0, 1'b0, 1'b0, OPC_J, 6'd0, 1'b1, X_F));
      rows.push_back(r(1'b0, 1'b0, 1'b0, 1'b0, OPC_J, 6'd0, 1'b1, X_F));
      rows.push_back(r(1'b0, 1'b0, 1'b0, 1'b0, OPC_J, 6'd0, 1'b1, X_F));
      rows.push_back(r(1'b0, 1'b0, 1'b0, 1'b0, OPC_J, 6'd0, 1'b1, X_FT));
    end
    rows.push_back(r(1'b0, 1'b0, 1'b0, 1'b0, OPC_J, 6'd0, 1'b1, X_F));
    rows.push_back(r(1'b0, 1'b0, 1'b0, 1'b0, OPC_J, 6'd0, 1'b1, X_F));
    rows.push_back(r(1'b0, 1'b0, 1'b0, 1'b0, OPC_J, 6'd0, 1'b1, X_F));
    rows.push_back(r(1'b0, 1'b1, 1'b0, 1'b0, OPC_J, 6'd0, 1'b1, X_FI));
    rows.push_back(r(1'b0, 1'b0, 1'b0, 1'b0, OPC_J, 6'd0, 1'b1, X_DD));
    rows.push_back(r(1'b0, 1'b0, 1'b0, 1'b0, OPC_J, 6'd0, 1'b1, X_F));
    for (int i = 0; i < rows.size(); i++) begin
      drive_row(rows[i]);
      if (rows[i].chk) begin
        e = exp_q.pop_front();
        checks++;
        if (obs !== e) begin
          errors++;
          $display("FAIL timeout_f cyc%0d: got %b expected %b", i, obs, e);
        end
      end
    end
  endtask

  // M timeout abandons the load; a second load gets dready exactly at the
  // threshold and must retire normally.
  task automatic test_timeout_m();
    row_t rows[$];
    logic [10:0] e;
    rows.push_back(rr());
    rows.push_back(r(1'b0, 1'b1, 1'b0, 1'b0, OPC_LW, 6'd0, 1'b1, X_FI));
    rows.push_back(r(1'b0, 1'b0, 1'b0, 1'b0, OPC_LW, 6'd0, 1'b1, X_D));
    rows.push_back(r(1'b0, 1'b0, 1'b0, 1'b0, OPC_LW, 6'd0, 1'b1, X_E));
    rows.push_back(r(1'b0, 1'b0, 1'b0, 1'b0, OPC_LW, 6'd0, 1'b1, X_M));
    rows.push_back(r(1'b0, 1'b0, 1'b0, 1'b0, OPC_LW, 6'd0, 1'b1, X_M));
    rows.push_back(r(1'b0, 1'b0, 1'b0, 1'b0, OPC_LW, 6'd0, 1'b1, X_M));
    rows.push_back(r(1'b0, 1'b0, 1'b0, 1'b0, OPC_LW, 6'd0, 1'b1, X_MT));
    rows.push_back(r(1'b0, 1'b1, 1'b0, 1'b0, OPC_LW, 6'd0, 1'b1, X_FI));
    rows.push_back(r(1'b0, 1'b0, 1'b0, 1'b0, OPC_LW, 6'd0, 1'b1, X_D));
    rows.push_back(r(1'b0, 1'b0, 1'b0, 1'b0, OPC_LW, 6'd0, 1'b1, X_E));
    rows.push_back(r(1'b0, 1'b0, 1'b0, 1'b0, OPC_LW, 6'd0, 1'b1, X_M));
    rows.push_back(r(1'b0, 1'b0, 1'b0, 1'b0, OPC_LW, 6'd0, 1'b1, X_M));
    rows.push_back(r(1'b0, 1'b0, 1'b0, 1'b0, OPC_LW, 6'd0, 1'b1, X_M));
    rows.push_back(r(1'b0, 1'b0, 1'b1, 1'b0, OPC_LW, 6'd0, 1'b1, X_M));
    rows.push_back(r(1'b0, 1'b0, 1'b0, 1'b0, OPC_LW, 6'd0, 1'b1, X_W));
    rows.push_back(r(1'b0, 1'b0, 1'b0, 1'b0, OPC_LW, 6'd0, 1'b1, X_F));
    for (int i = 0; i < rows.size(); i++) begin
      drive_row(rows[i]);
      if (rows[i].chk) begin
        e = exp_q.pop_front();
        checks++;
        if (obs !== e) begin
          errors++;
          $display("FAIL timeout_m cyc%0d: got %b expected %b", i, obs, e);
        end
      end
    end
  endtask

  // ADDI stalled in E and W; stall in F is ignored.
  task automatic test_stall();
    row_t rows[$];
    logic [10:0] e;
    rows.push_back(rr());
    rows.push_back(r(1'b0, 1'b1, 1'b0, 1'b1, OPC_ADDI, 6'd0, 1'b1, X_FI));
    rows.push_back(r(1'b0, 1'b0, 1'b0, 1'b0, OPC_ADDI, 6'd0, 1'b1, X_D));
    rows.push_back(r(1'b0, 1'b0, 1'b0, 1'b1, OPC_ADDI, 6'd0, 1'b1, X_E));
    rows.push_back(r(1'b0, 1'b0, 1'b0, 1'b1, OPC_ADDI, 6'd0, 1'b1, X_E));
    rows.push_back(r(1'b0, 1'b0, 1'b0, 1'b0, OPC_ADDI, 6'd0, 1'b1, X_E));
    rows.push_back(r(1'b0, 1'b0, 1'b0, 1'b1, OPC_ADDI, 6'd0, 1'b1, X_WS));
    rows.push_back(r(1'b0, 1'b0, 1'b0, 1'b0, OPC_ADDI, 6'd0, 1'b1, X_W));
    rows.push_back(r(1'b0, 1'b0, 1'b0, 1'b0, OPC_ADDI, 6'd0, 1'b1, X_F));
    for (int i = 0; i < rows.size(); i++) begin
      drive_row(rows[i]);
      if (rows[i].chk) begin
        e = exp_q.pop_front();
        checks++;
        if (obs !== e) begin
          errors++;
          $display("FAIL stall cyc%0d: got %b expected %b", i, obs, e);
        end
      end
    end
  endtask

  // NOP, J (op input changed during D to prove the latched copy is decoded),
  // BEQ and a D-stalled R-type run back to back.
  task automatic test_back_to_back();
    row_t rows[$];
    logic [10:0] e;
    rows.push_back(rr());
    rows.push_back(r(1'b0, 1'b1, 1'b0, 1'b0, OPC_R, 6'b000000, 1'b1, X_FI));
    rows.push_back(r(1'b0, 1'b0, 1'b0, 1'b0, OPC_R, 6'b000000, 1'b1, X_DD));
    rows.push_back(r(1'b0, 1'b1, 1'b0, 1'b0, OPC_J, 6'd0, 1'b1, X_FI));
    rows.push_back(r(1'b0, 1'b0, 1'b0, 1'b0, OPC_LW, 6'd0, 1'b1, X_DD));
    rows.push_back(r(1'b0, 1'b1, 1'b0, 1'b0, OPC_BEQ, 6'd0, 1'b1, X_FI));
    rows.push_back(r(1'b0, 1'b0, 1'b0, 1'b0, OPC_BEQ, 6'd0, 1'b1, X_D));
    rows.push_back(r(1'b0, 1'b0, 1'b0, 1'b0, OPC_BEQ, 6'd0, 1'b1, X_ED));
    rows.push_back(r(1'b0, 1'b1, 1'b0, 1'b1, OPC_R, 6'b100000, 1'b1, X_FI));
    rows.push_back(r(1'b0, 1'b0, 1'b0, 1'b1, OPC_R, 6'b100000, 1'b1, X_D));
    rows.push_back(r(1'b0, 1'b0, 1'b0, 1'b0, OPC_R, 6'b100000, 1'b1, X_D));
    rows.push_back(r(1'b0, 1'b0, 1'b0, 1'b0, OPC_R, 6'b100000, 1'b1, X_E));
    rows.push_back(r(1'b0, 1'b0, 1'b0, 1'b0, OPC_R, 6'b100000, 1'b1, X_W));
    rows.push_back(r(1'b0, 1'b0, 1'b0, 1'b0, OPC_R, 6'b100000, 1'b1, X_F));
    for (int i = 0; i < rows.size(); i++) begin
      drive_row(rows[i]);
      if (rows[i].chk) begin
        e = exp_q.pop_front();
        checks++;
        if (obs !== e) begin
          errors++;
          $display("FAIL back_to_back cyc%0d: got %b expected %b", i, obs, e);
        end
      end
    end
  endtask

  // Reset while a load waits in M: next cycle is a clean F with no retire.
  task automatic test_reset_in_m();
    row_t rows[$];
    logic [10:0] e;
    rows.push_back(rr());
    rows.push_back(r(1'b0, 1'b1, 1'b0, 1'b0, OPC_LW, 6'd0, 1'b1, X_FI));
    rows.push_back(r(1'b0, 1'b0, 1'b0, 1'b0, OPC_LW, 6'd0, 1'b1, X_D));
    rows.push_back(r(1'b0, 1'b0, 1'b0, 1'b0, OPC_LW, 6'd0, 1'b1, X_E));
    rows.push_back(r(1'b0, 1'b0, 1'b0, 1'b0, OPC_LW, 6'd0, 1'b1, X_M));
    rows.push_back(r(1'b1, 1'b0, 1'b0, 1'b0, OPC_LW, 6'd0, 1'b1, X_M));
    rows.push_back(r(1'b0, 1'b0, 1'b0, 1'b0, OPC_LW, 6'd0, 1'b1, X_F));
    rows.push_back(r(1'b0, 1'b0, 1'b0, 1'b0, OPC_LW, 6'd0, 1'b1, X_F));
    for (int i = 0; i < rows.size(); i++) begin
      drive_row(rows[i]);
      if (rows[i].chk) begin
        e = exp_q.pop_front();
        checks++;
        if (obs !== e) begin
          errors++;
          $display("FAIL reset_in_m cyc%0d: got %b expected %b", i, obs, e);
        end
      end
    end
  endtask

  initial begin
    reset  = 1'b1;
    iready = 1'b0;
    dready = 1'b0;
    stall  = 1'b0;
    op     = 6'd0;
    func   = 6'd0;
    test_reset();
    test_lw();
    test_sw();
    test_illegal();
    test_timeout_f();
    test_timeout_m();
    test_stall();
    test_back_to_back();
    test_reset_in_m();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 Parameter OP_W, default 6, opcode width.
REQ-002 Parameter FUNC_W, default 6, R-type function-field width.
REQ-003 Parameter TIMEOUT, default 15, maximum wait cycles in F or M before abort; 0 disables the timeout.
REQ-004 clk  input  1  sole clock; all state changes on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 op  input  OP_W  opcode of the instruction arriving from instruction memory.
REQ-007 func  input  FUNC_W  function field of that instruction.
REQ-008 iready  input  1  instruction memory has returned data.
REQ-009 dready  input  1  data memory access is complete.
REQ-010 stall  input  1  hold request from the datapath.
REQ-011 state  output  3  current state: F=001, D=010, E=011, M=100, W=101.
REQ-012 ireq  output  1  instruction fetch request.
REQ-013 dreq  output  1  data memory request.
REQ-014 dwe  output  1  data memory write enable.
REQ-015 ir_we  output  1  instruction register write enable.
REQ-016 rf_we  output  1  register file write enable.
REQ-017 instr_done  output  1  one-cycle pulse on instruction retire.
REQ-018 err_illegal  output  1  one-cycle pulse on an undecodable opcode.
REQ-019 err_timeout  output  1  one-cycle pulse on a handshake timeout.

Function
REQ-020 The block SHALL latch op and func into internal registers on the F cycle in which iready=1, and SHALL decode only the latched values.
REQ-021 Decode SHALL use the following opcodes: R=000000, ADDI=001000, J=000010, BEQ=000100, LW=100011, SW=101011; an R-type with func=000000 is NOP.
REQ-022 The state sequences SHALL be: NOP F-D-F; J F-D-F; R and ADDI F-D-E-W-F; BEQ F-D-E-F; LW F-D-E-M-W-F; SW F-D-E-M-F.
REQ-023 In F the block SHALL assert ireq, and SHALL remain in F while iready=0.
REQ-024 The block SHALL leave F for D on the cycle iready=1, asserting ir_we combinationally in that cycle only.
REQ-025 In M the block SHALL assert dreq, assert dwe for SW only, and remain in M while dready=0.
REQ-026 The block SHALL leave M on the cycle dready=1.
REQ-027 stall=1 SHALL hold the state in D, E or W; in F and M stall SHALL be ignored and only the handshake governs.
REQ-028 rf_we SHALL be asserted in W only, and SHALL be forced low while stall=1.
REQ-029 instr_done SHALL pulse in the last cycle of each instruction, that is the unstalled cycle whose next state is F after a valid decode (D for NOP/J, E for BEQ, M for SW with dready=1, W for the others).
REQ-030 An unlisted opcode SHALL pulse err_illegal in D (unstalled), go to F next, and SHALL NOT pulse instr_done.
REQ-031 A wait counter of width $clog2(TIMEOUT+1) SHALL increment each F or M cycle in which the ready signal is 0, and SHALL clear on a state change.
REQ-032 When TIMEOUT>0, the counter equals TIMEOUT and ready is still 0, the block SHALL pulse err_timeout, go to F (from M, abandoning the instruction without instr_done), and clear the counter; in F it SHALL re-request.
REQ-033 If ready=1 in the same cycle the counter reaches TIMEOUT, the handshake SHALL complete normally and no err_timeout SHALL occur.
REQ-034 All outputs other than state SHALL be 0 in any state or condition not listed above.

Reset
REQ-035 When reset=1 at a clock edge, the block SHALL set state=F, clear the wait counter and clear the latched op/func to 0, aborting any instruction in flight, including one waiting in M.
REQ-036 In the first cycle after reset, ireq SHALL be 1 and all other control outputs SHALL be 0.

Verification
REQ-037 LW (op=100011) with iready=1 at once and dready after 2 wait cycles -> states F,D,E,M,M,M,W,F; dreq high for 3 cycles; rf_we 1 in W; instr_done 1 in W.
REQ-038 SW (op=101011) with dready=1 immediately -> F,D,E,M,F; dwe=1 in M; rf_we never 1; instr_done in M.
REQ-039 op=111111 -> F,D,F; err_illegal pulses once in D; no instr_done.
REQ-040 TIMEOUT=3, iready held 0 -> err_timeout pulses on the 4th F cycle, the counter restarts, and ireq stays 1 throughout.
REQ-041 ADDI with stall=1 for 2 cycles in E -> E held 3 cycles, then W; rf_we held low while stalled in W.
REQ-042 reset=1 asserted while in M waiting on dready -> next state F, dreq=0, no instr_done.
